bcd_stopwatch: RTL
==================

# bcd_stopwatch

Four-digit MM:SS BCD up/down timer that generates the digit nibbles consumed by the per-digit `bcdto7segment` decoders on the board display path. A parameterised prescaler derives a one-second count enable from the system clock. The block supports start, stop, clear and countdown-preset load, and raises a sticky `done` flag when a countdown expires. All outputs are registered and drive the decoders directly, with no further formatting.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per count step, for 1 Hz from 50 MHz. Legal range is ≥1, and 1 means a step every cycle. Prescaler width is max(1, $clog2(TICK_DIV)).
- `clk` input 1: the only clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high. It is sampled only on the rising edge of `clk`.
- `start` input 1: single-cycle pulse that sets running.
- `stop` input 1: single-cycle pulse that clears running.
- `clear` input 1: sets digits to 00:00, idle, `done`=0.
- `load` input 1: loads `load_value` into the digits, idle, `done`=0.
- `load_value` input 16: BCD {min_tens, min_ones, sec_tens, sec_ones}.
- `count_down` input 1: 1 counts down, 0 counts up. Sampled at every step.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: BCD digits to the decoders.
- `running` output 1: the counter is advancing.
- `done` output 1: sticky countdown-expired flag.

## Operation
- Reset value of every output and internal register is 0: digits 00:00, `running`=0, `done`=0, prescaler=0.
- Priority per edge, highest first: `reset` > `clear` > `load` > `stop` > `start` > step.
- **clear:** digits=0, prescaler=0, `running`=0, `done`=0.
- **load:** digits=`load_value` with per-digit clamp, prescaler=0, `running`=0, `done`=0.
  - Clamp rule: ones digits >9 become 9; tens digits >5 become 5.
- **stop:** `running`=0. Prescaler holds its value, so a pause resumes mid-second.
- **start**, applied only if `stop`, `clear` and `load` are all low:
  - Start is ignored when `count_down`=1 and the digits are 00:00. `running` stays 0 and `done` is unchanged.
  - Otherwise `running`=1 and `done`=0.
  - Start while already running has no effect.
- **Prescaler:** advances only in cycles where `running`=1 and no control input is asserted. It counts 0..TICK_DIV-1 and wraps to 0. The wrap cycle is the step.
- **Up step:**
  - `sec_ones` increments 0..9. On 9→0 it carries to `sec_tens` (0..5).
  - `sec_tens` 5→0 carries to `min_ones` (0..9), and 9→0 carries to `min_tens` (0..5).
  - 59:59 wraps to 00:00 and keeps running. `done` is unaffected.
- **Down step:**
  - Each digit decrements with borrow: 0→9 for ones and 0→5 for tens.
  - When the value before the step is 00:01, the same edge sets digits to 00:00, `running`=0 and `done`=1.
  - Running down from 00:00 is unreachable, because start is blocked. If `count_down` changes to 1 while the value is 00:00 and running, the next step holds 00:00, sets `running`=0 and sets `done`=1.
- `count_down` may change mid-run. The new direction applies from the next step.
- `done` stays 1 until `clear`, `load`, `reset` or an accepted `start`.

## Timing
- All outputs are registered. Every control input takes effect on the first rising edge where it is high, and outputs reflect it one cycle later.
- `start` asserted at edge N gives `running`=1 after N. With the prescaler at 0, the first step occurs at edge N+TICK_DIV. Steps then repeat every TICK_DIV cycles.
- Digit update and `done` assertion happen on the same edge as the step. There is no additional latency.
- A `stop` coincident with a prescaler wrap suppresses that step. The prescaler stays at TICK_DIV-1, and the step fires on the first running cycle after the next accepted `start`.
- Reset mid-count returns everything to reset values on that edge. A `start` in the same cycle as `reset` is ignored.
- Control inputs are synchronous to `clk`. Debounce and synchronisation of board buttons happen upstream.

## Test plan
- TICK_DIV=4: reset, pulse `start`, run 240 cycles → digits 01:00, `running`=1. Continue to 59:59 and one more step → 00:00, still running.
- TICK_DIV=4: `load`=16'h0002, `count_down`=1, `start` → 00:01 after 4 cycles. At 8 cycles: 00:00, `running`=0, `done`=1. A subsequent `start` is ignored and `done` stays 1.
- `load`=16'hFAFB → digits 59:59 (clamp: min_tens F→5, min_ones A→9, sec_tens F→5, sec_ones B→9).
- TICK_DIV=4, running: `stop` after 2 cycles into a second, idle 10 cycles, `start` → next step exactly 2 running cycles later. Also pulse `stop` on a wrap cycle → the step is suppressed.
- Simultaneous `start`+`stop` → `running`=0. `clear`+`load` → 00:00. `reset` asserted mid-count with `start` high → all outputs 0 on the next cycle.
- TICK_DIV=1, up from 00:09, then switch `count_down`=1 at 00:10 → one more up step to 00:11, then down steps 00:10, 00:09, one per cycle.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: MM:SS BCD up/down timer with prescaled step, start/stop/clear/load and sticky done.
module bcd_stopwatch #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        count_down,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones,
  output logic        running,
  output logic        done
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pre;
  logic          dir;
  logic [15:0]   digits, up, dn;
  logic          c1, c2, c3, b1, b2, b3, zero, expire;
  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] m);
    return v > m ? m : v;
  endfunction
  assign digits = {min_tens, min_ones, sec_tens, sec_ones};
  always_comb begin
    c1 = sec_ones == 4'd9;
    c2 = c1 && sec_tens == 4'd5;
    c3 = c2 && min_ones == 4'd9;
    b1 = sec_ones == 4'd0;
    b2 = b1 && sec_tens == 4'd0;
    b3 = b2 && min_ones == 4'd0;
    up = {c3 ? (min_tens == 4'd5 ? 4'd0 : min_tens + 4'd1) : min_tens,
          c2 ? (min_ones == 4'd9 ? 4'd0 : min_ones + 4'd1) : min_ones,
          c1 ? (sec_tens == 4'd5 ? 4'd0 : sec_tens + 4'd1) : sec_tens,
          c1 ? 4'd0 : sec_ones + 4'd1};
    dn = {b3 ? (min_tens == 4'd0 ? 4'd5 : min_tens - 4'd1) : min_tens,
          b2 ? (min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1) : min_ones,
          b1 ? (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1) : sec_tens,
          b1 ? 4'd9 : sec_ones - 4'd1};
    zero = digits == 16'h0000;
    expire = dir && digits <= 16'h0001;
  end
  // dir lags count_down by one cycle, so a direction change takes effect from the following step
  always_ff @(posedge clk) begin
    if (reset) begin
      {min_tens, min_ones, sec_tens, sec_ones} <= '0;
      pre <= '0;
      running <= 1'b0;
      done <= 1'b0;
      dir <= 1'b0;
    end else begin
      dir <= count_down;
      if (clear) begin
        {min_tens, min_ones, sec_tens, sec_ones} <= '0;
        pre <= '0;
        running <= 1'b0;
        done <= 1'b0;
      end else if (load) begin
        {min_tens, min_ones, sec_tens, sec_ones} <= {clamp(load_value[15:12], 4'd5),
          clamp(load_value[11:8], 4'd9), clamp(load_value[7:4], 4'd5), clamp(load_value[3:0], 4'd9)};
        pre <= '0;
        running <= 1'b0;
        done <= 1'b0;
      end else if (stop) begin
        running <= 1'b0;
      end else if (start) begin
        if (!running && !(count_down && zero)) begin
          running <= 1'b1;
          done <= 1'b0;
        end
      end else if (running) begin
        if (pre == LAST) begin
          pre <= '0;
          if (expire) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= '0;
            running <= 1'b0;
            done <= 1'b1;
          end else begin
            {min_tens, min_ones, sec_tens, sec_ones} <= dir ? dn : up;
          end
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end
endmodule
